// File: rtl/voltage_window_logger.sv
// Averages fixed windows of 2^WIN_LOG2 voltage samples, tracks per-window min/max,
// and queues the averages in a show-ahead FIFO for telemetry readout.
module voltage_window_logger #(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned WIN_LOG2   = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample_data,
  input  logic                clear,
  input  logic                rd_en,
  output logic                avg_valid,
  output logic [DATA_W-1:0]   avg_data,
  output logic                fifo_full,
  output logic                overflow,
  output logic [DATA_W-1:0]   min_v,
  output logic [DATA_W-1:0]   max_v,
  output logic [WIN_LOG2-1:0] win_count
);

  localparam int unsigned ACC_W = DATA_W + WIN_LOG2;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_PUSH} state_t;

  state_t                r_state, w_next;
  logic [ACC_W-1:0]      r_acc;
  logic [DATA_W-1:0]     r_run_min, r_run_max, r_avg, r_min_v, r_max_v;
  logic [WIN_LOG2-1:0]   r_win_count;

  logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_overflow;

  logic                  w_take, w_open, w_add, w_last;
  logic [ACC_W-1:0]      w_sum;
  logic [DATA_W-1:0]     w_min, w_max;
  logic                  w_empty, w_full, w_push, w_pop, w_wr;

  assign w_take = sample_valid && !clear;
  // PUSH behaves like IDLE for an incoming sample so back-to-back windows lose nothing
  assign w_open = w_take && (r_state != S_ACC);
  assign w_add  = w_take && (r_state == S_ACC);
  assign w_last = w_add && (r_win_count == '1);
  assign w_sum  = r_acc + ACC_W'(sample_data);
  assign w_min  = (sample_data < r_run_min) ? sample_data : r_run_min;
  assign w_max  = (sample_data > r_run_max) ? sample_data : r_run_max;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_take) w_next = S_ACC;
      S_ACC:   if (w_last) w_next = S_PUSH;
      S_PUSH:  w_next = w_take ? S_ACC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (clear) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_acc       <= '0;
      r_run_min   <= '0;
      r_run_max   <= '0;
      r_avg       <= '0;
      r_win_count <= '0;
      if (rst) begin
        r_min_v <= '0;
        r_max_v <= '0;
      end
    end else if (w_open) begin
      r_acc       <= ACC_W'(sample_data);
      r_run_min   <= sample_data;
      r_run_max   <= sample_data;
      r_win_count <= WIN_LOG2'(1);
    end else if (w_add) begin
      if (w_last) begin
        r_avg       <= DATA_W'(w_sum >> WIN_LOG2);
        r_min_v     <= w_min;
        r_max_v     <= w_max;
        r_acc       <= '0;
        r_win_count <= '0;
      end else begin
        r_acc       <= w_sum;
        r_run_min   <= w_min;
        r_run_max   <= w_max;
        r_win_count <= r_win_count + WIN_LOG2'(1);
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_push  = (r_state == S_PUSH) && !clear && !rst;
  assign w_pop   = rd_en && !w_empty && !clear && !rst;
  // A full FIFO still accepts the push when the head leaves in the same cycle
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_avg;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (AW+1)'(1);
      if (w_push && !w_wr) r_overflow <= 1'b1;
    end
  end

  assign avg_valid = !w_empty;
  assign avg_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_full = w_full;
  assign overflow  = r_overflow;
  assign min_v     = r_min_v;
  assign max_v     = r_max_v;
  assign win_count = r_win_count;

endmodule

// File: tb/tb_voltage_window_logger.sv
// Directed self-checking bench for voltage_window_logger: window averaging,
// min/max, FIFO ordering/full/overflow, and clear/reset mid-window.
module tb_voltage_window_logger;

  logic       clk = 1'b0;
  logic       rst, sample_valid, clear, rd_en;
  logic [8:0] sample_data;
  logic       avg_valid, fifo_full, overflow;
  logic [8:0] avg_data, min_v, max_v;
  logic [2:0] win_count;

  int total = 0;
  int bad   = 0;

  voltage_window_logger #(.DATA_W(9), .WIN_LOG2(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .clear(clear), .rd_en(rd_en), .avg_valid(avg_valid), .avg_data(avg_data),
    .fifo_full(fifo_full), .overflow(overflow), .min_v(min_v), .max_v(max_v),
    .win_count(win_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [8:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_data  = v;
      tick();
    end
  endtask

  task automatic idle();
    sample_valid = 1'b0;
    sample_data  = '0;
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_data = '0; clear = 1'b0; rd_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_avg_data", avg_data, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_min", min_v, 0);
    chk("rst_max", max_v, 0);
    chk("rst_win_count", win_count, 0);

    // 1: single window of 50, latency two edges after completing sample
    feed(50, 5);
    chk("t1_win_count5", win_count, 5);
    feed(50, 3);
    chk("t1_not_yet_valid", avg_valid, 0);
    chk("t1_win_count0", win_count, 0);
    idle();
    chk("t1_valid", avg_valid, 1);
    chk("t1_avg", avg_data, 50);
    chk("t1_min", min_v, 50);
    chk("t1_max", max_v, 50);
    pop();
    chk("t1_empty", avg_valid, 0);
    feed(50, 16);
    idle();
    chk("t1b_head0", avg_data, 50);
    pop();
    chk("t1b_second_valid", avg_valid, 1);
    chk("t1b_head1", avg_data, 50);
    pop();
    chk("t1b_empty", avg_valid, 0);

    // 2: mixed window, min/max update
    feed(50, 4); feed(90, 4); idle();
    chk("t2_avg", avg_data, 70);
    chk("t2_min", min_v, 50);
    chk("t2_max", max_v, 90);
    pop();
    chk("t2_valid_after_pop", avg_valid, 0);
    chk("t2_data_after_pop", avg_data, 0);

    // 3: truncation and full-scale
    feed(7, 1); feed(0, 7); idle();
    chk("t3_trunc_avg", avg_data, 0);
    chk("t3_trunc_valid", avg_valid, 1);
    chk("t3_trunc_max", max_v, 7);
    pop();
    feed(510, 8); idle();
    chk("t3_max_avg", avg_data, 510);
    chk("t3_max_ovf", overflow, 0);
    chk("t3_max_min", min_v, 510);
    pop();

    // 4: fill, then drop on full
    feed(10, 8); idle();
    feed(20, 8); idle();
    feed(30, 8); idle();
    chk("t4_not_full3", fifo_full, 0);
    feed(40, 8); idle();
    chk("t4_full", fifo_full, 1);
    chk("t4_no_ovf_yet", overflow, 0);
    feed(60, 8); idle();
    chk("t4_ovf", overflow, 1);
    chk("t4_still_full", fifo_full, 1);
    chk("t4_max_tracks_dropped", max_v, 60);
    chk("t4_h0", avg_data, 10); pop();
    chk("t4_h1", avg_data, 20); pop();
    chk("t4_h2", avg_data, 30); pop();
    chk("t4_h3", avg_data, 40); pop();
    chk("t4_empty", avg_valid, 0);
    chk("t4_ovf_sticky", overflow, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t4_ovf_cleared", overflow, 0);

    // 5: full FIFO, read in the PUSH cycle
    feed(11, 8); idle();
    feed(22, 8); idle();
    feed(33, 8); idle();
    feed(44, 8); idle();
    feed(55, 8);
    sample_valid = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t5_full", fifo_full, 1);
    chk("t5_ovf", overflow, 0);
    chk("t5_h0", avg_data, 22); pop();
    chk("t5_h1", avg_data, 33); pop();
    chk("t5_h2", avg_data, 44); pop();
    chk("t5_tail", avg_data, 55); pop();
    chk("t5_empty", avg_valid, 0);

    // 6: clear and reset mid-window
    feed(100, 5);
    clear = 1'b1; sample_valid = 1'b1; sample_data = 9'd100; rd_en = 1'b1;
    tick();
    clear = 1'b0; sample_valid = 1'b0; rd_en = 1'b0;
    chk("t6_clr_win", win_count, 0);
    chk("t6_clr_empty", avg_valid, 0);
    chk("t6_clr_ovf", overflow, 0);
    chk("t6_clr_min_hold", min_v, 55);
    chk("t6_clr_max_hold", max_v, 55);
    feed(20, 8); idle();
    chk("t6_clr_avg", avg_data, 20);
    pop();
    feed(30, 8);
    clear = 1'b1; sample_valid = 1'b0;
    tick();
    clear = 1'b0;
    tick();
    chk("t6_clr_push_discard", avg_valid, 0);
    feed(200, 3);
    rst = 1'b1; sample_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("t6_rst_win", win_count, 0);
    chk("t6_rst_min", min_v, 0);
    chk("t6_rst_max", max_v, 0);
    feed(20, 8); idle();
    chk("t6_rst_avg", avg_data, 20);
    chk("t6_rst_min20", min_v, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
